ara_scoreboard_issuer: RTL
==========================

Name: ara_scoreboard_issuer

Overview:
Parametrised successor of Ara's sequencer core. It allocates vector-instruction IDs and tracks which PEs still run each instruction. It computes RAW/WAR/WAW hazard vectors with full multi-reader tracking per vector register, then broadcasts each instruction to a selectable subset of PEs, latching per-PE acknowledgements. It sits between the dispatcher and the lanes/VLSU/SLDU/MASKU; the scalar-response/WAIT path stays in the dispatcher.

Parameters:
NrLanes, 4, number of lanes
NrVInsn, 8, maximum in-flight vector instructions (ID width = clog2(NrVInsn), minimum 1)
NrVRegs, 32, architectural vector registers (index width = clog2(NrVRegs)); register 0 is the mask register
NrPEs, NrLanes+4, processing elements (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  dispatcher request valid
req_ready_o  out  1  request accepted when valid&ready
req_pe_mask_i  in  NrPEs  PEs that execute the instruction
req_vs1_i / req_vs2_i / req_vd_i  in  clog2(NrVRegs) each  register indices
req_use_vs1_i / req_use_vs2_i / req_use_vd_i  in  1 each  operand used
req_vm_i  in  1  0 = masked (reads register 0)
issue_valid_o  out  1  registered issue broadcast valid
issue_id_o  out  clog2(NrVInsn)  allocated ID
issue_pe_mask_o  out  NrPEs  latched req_pe_mask_i
hazard_vs1_o / hazard_vs2_o / hazard_vm_o / hazard_vd_o  out  NrVInsn each  IDs this instruction must wait on
pe_ready_i  in  NrPEs  per-PE ready for the broadcast
pe_done_i  in  NrPEs x NrVInsn  per-PE one-cycle completion pulses
vinsn_running_o  out  NrVInsn  OR over PEs of running bits (combinational _d value)
idle_o  out  1  no instruction running (registered)

Behaviour:
- Reset (async, rst_ni low): state IDLE; all running, reader, writer and acked state cleared; issue_valid_o=0; issue_id_o, issue_pe_mask_o and all hazard outputs 0; idle_o=1; req_ready_o=1.
- Running bits per PE are updated each cycle as running_d[pe] = running_q[pe] & ~pe_done_i[pe], then OR'd with the new allocation. Done pulses for bits that are not set are ignored.
- An ID is free when its bit is clear in running_q. The allocated ID is the lowest free index.
- req_ready_o = (state==IDLE) && a free ID exists.
- On acceptance of a request with req_pe_mask_i==0: dropped; no ID allocated, no state change, no issue.
- On acceptance of a request with non-zero mask (cycle N):
  - Set running_d[pe][id] for each pe in the mask.
  - Hazard vectors are computed from pre-update tables:
    - RAW: hazard_vs1 = writer of vs1 if use_vs1; same for vs2; hazard_vm = writer of register 0 if !vm.
    - WAR: hazard_vd |= reader mask of vd if use_vd.
    - WAW: hazard_vd |= writer of vd if use_vd.
  - Then update the tables: writer[vd]={id,valid}; reader mask bit id set for vs1/vs2/register 0 as used.
  - State goes to ISSUE. At N+1, issue_valid_o=1 with id, mask and hazards.
- Table pruning, every cycle: writer valid &= vinsn_running_q[writer id]; reader masks &= vinsn_running_q.
- ISSUE state:
  - Outputs are held.
  - Hazard outputs are re-ANDed with vinsn_running_d every cycle.
  - acked_q |= pe_ready_i & mask while issue_valid_o.
  - When (acked_q | pe_ready_i) covers the mask, drop issue_valid_o the next cycle, clear acked_q and return to IDLE.
  - req_ready_o=0 throughout ISSUE and in the completing cycle.
- A PE may complete (done pulse) an issued instruction before all PEs have acked. Completion and ack are independent.
- A done pulse for an ID in the same cycle as its allocation cannot occur, because the ID was free.
- idle_o = !(|vinsn_running_q).

Test Plan:
- Reset, then request vd=3, mask=0x0F, all ready → issue_valid_o at N+1, id=0, all hazards 0; idle_o=0 at N+1.
- Write v3 (id0) then read vs1=3 → second issue id=1, hazard_vs1=0x01. Pulse done for id0 on all four lanes → hazard_vs1 reads 0x00 the next cycle while held.
- Two readers of v5 (ids 0,1) still running, then write vd=5 → hazard_vd=0x03 (multi-reader WAR).
- Mask=0x0F with pe_ready_i staggered 0x01,0x02,0x0C over three cycles → issue_valid_o holds for three cycles; req_ready_o returns 1 one cycle later.
- Allocate NrVInsn instructions with no done pulses → req_ready_o=0. One instruction completes on all its PEs → req_ready_o=1 next cycle and that freed ID is reused.
- Assert rst_ni low mid-ISSUE → issue_valid_o=0 and idle_o=1 immediately; tables are empty after reset release.

Source files
------------

// File: rtl/ara_scoreboard_issuer_if.sv
// Dispatcher/PE-facing bundle of the vector-instruction scoreboard and issuer.
// The design takes the slave modport. The dispatcher/PE side takes the master modport.
interface ara_scoreboard_issuer_if #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned NrVInsn = 8,
  parameter int unsigned NrVRegs = 32
);
  localparam int unsigned NrPEs = NrLanes + 4;
  localparam int unsigned IdW   = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
  localparam int unsigned RegW  = (NrVRegs > 1) ? $clog2(NrVRegs) : 1;

  // Request from the dispatcher
  logic                            req_valid_i;
  logic                            req_ready_o;
  logic [NrPEs-1:0]                req_pe_mask_i;
  logic [RegW-1:0]                 req_vs1_i;
  logic [RegW-1:0]                 req_vs2_i;
  logic [RegW-1:0]                 req_vd_i;
  logic                            req_use_vs1_i;
  logic                            req_use_vs2_i;
  logic                            req_use_vd_i;
  logic                            req_vm_i;

  // Issue broadcast towards the PEs
  logic                            issue_valid_o;
  logic [IdW-1:0]                  issue_id_o;
  logic [NrPEs-1:0]                issue_pe_mask_o;
  logic [NrVInsn-1:0]              hazard_vs1_o;
  logic [NrVInsn-1:0]              hazard_vs2_o;
  logic [NrVInsn-1:0]              hazard_vm_o;
  logic [NrVInsn-1:0]              hazard_vd_o;

  // PE feedback and status
  logic [NrPEs-1:0]                pe_ready_i;
  logic [NrPEs-1:0][NrVInsn-1:0]   pe_done_i;
  logic [NrVInsn-1:0]              vinsn_running_o;
  logic                            idle_o;

  modport slave (
    input  req_valid_i, req_pe_mask_i, req_vs1_i, req_vs2_i, req_vd_i,
           req_use_vs1_i, req_use_vs2_i, req_use_vd_i, req_vm_i,
           pe_ready_i, pe_done_i,
    output req_ready_o, issue_valid_o, issue_id_o, issue_pe_mask_o,
           hazard_vs1_o, hazard_vs2_o, hazard_vm_o, hazard_vd_o,
           vinsn_running_o, idle_o
  );

  modport master (
    output req_valid_i, req_pe_mask_i, req_vs1_i, req_vs2_i, req_vd_i,
           req_use_vs1_i, req_use_vs2_i, req_use_vd_i, req_vm_i,
           pe_ready_i, pe_done_i,
    input  req_ready_o, issue_valid_o, issue_id_o, issue_pe_mask_o,
           hazard_vs1_o, hazard_vs2_o, hazard_vm_o, hazard_vd_o,
           vinsn_running_o, idle_o
  );
endinterface

// File: rtl/ara_scoreboard_issuer.sv
// Vector-instruction scoreboard and issuer.
// The block allocates instruction IDs and tracks the running bits of each PE.
// It derives RAW/WAR/WAW hazard vectors from per-register writer/reader tables.
// It broadcasts each accepted instruction to its PE subset until every PE has acknowledged.
module ara_scoreboard_issuer #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned NrVInsn = 8,
  parameter int unsigned NrVRegs = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ara_scoreboard_issuer_if.slave bus
);
  localparam int unsigned NrPEs = NrLanes + 4;
  localparam int unsigned IdW   = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
  localparam int unsigned RegW  = (NrVRegs > 1) ? $clog2(NrVRegs) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e                          state_r;
  logic [NrPEs-1:0][NrVInsn-1:0]   running_r;
  logic [NrPEs-1:0][NrVInsn-1:0]   running_s;
  logic [NrVInsn-1:0]              vinsn_cur_s;
  logic [NrVInsn-1:0]              vinsn_next_s;
  logic [NrVInsn-1:0]              id_oh_s;
  logic [IdW-1:0]                  free_id_s;
  logic                            free_found_s;
  logic                            req_ready_s;
  logic                            alloc_s;
  logic                            ack_done_s;

  logic [NrVRegs-1:0][IdW-1:0]     writer_id_r;
  logic [NrVRegs-1:0][IdW-1:0]     writer_id_s;
  logic [NrVRegs-1:0]              writer_valid_r;
  logic [NrVRegs-1:0]              writer_valid_s;
  logic [NrVRegs-1:0][NrVInsn-1:0] writer_oh_s;
  logic [NrVRegs-1:0][NrVInsn-1:0] reader_r;
  logic [NrVRegs-1:0][NrVInsn-1:0] reader_live_s;
  logic [NrVRegs-1:0][NrVInsn-1:0] reader_s;

  logic [NrVInsn-1:0]              haz_vs1_s, haz_vs2_s, haz_vm_s, haz_vd_s;
  logic [NrVInsn-1:0]              haz_vs1_r, haz_vs2_r, haz_vm_r, haz_vd_r;
  logic                            issue_valid_r;
  logic [IdW-1:0]                  issue_id_r;
  logic [NrPEs-1:0]                issue_mask_r;
  logic [NrPEs-1:0]                acked_r;
  logic                            idle_r;

  // Occupancy per ID and lowest free ID (with its one-hot form)
  always_comb begin
    vinsn_cur_s  = {NrVInsn{1'b0}};
    free_found_s = 1'b0;
    free_id_s    = {IdW{1'b0}};
    id_oh_s      = {NrVInsn{1'b0}};
    for (int p = 0; p < int'(NrPEs); p++) begin
      vinsn_cur_s = vinsn_cur_s | running_r[p];
    end
    for (int i = int'(NrVInsn) - 1; i >= 0; i--) begin
      free_found_s = free_found_s | ~vinsn_cur_s[i];
      free_id_s    = vinsn_cur_s[i] ? free_id_s : IdW'(i);
    end
    for (int i = 0; i < int'(NrVInsn); i++) begin
      id_oh_s[i] = (free_id_s == IdW'(i));
    end
  end

  assign req_ready_s = (state_r == ST_IDLE) & free_found_s;
  assign alloc_s     = bus.req_valid_i & req_ready_s & (|bus.req_pe_mask_i);
  assign ack_done_s  = (((acked_r | bus.pe_ready_i) & issue_mask_r) == issue_mask_r);

  // Next running bits: retire done pulses, then add the new allocation
  always_comb begin
    running_s    = {(NrPEs*NrVInsn){1'b0}};
    vinsn_next_s = {NrVInsn{1'b0}};
    for (int p = 0; p < int'(NrPEs); p++) begin
      running_s[p] = (running_r[p] & ~bus.pe_done_i[p]) |
                     ((alloc_s & bus.req_pe_mask_i[p]) ? id_oh_s : {NrVInsn{1'b0}});
      vinsn_next_s = vinsn_next_s | running_s[p];
    end
  end

  // Pruned tables, hazard lookup and table update for the incoming instruction
  always_comb begin
    writer_oh_s    = {(NrVRegs*NrVInsn){1'b0}};
    reader_live_s  = {(NrVRegs*NrVInsn){1'b0}};
    reader_s       = {(NrVRegs*NrVInsn){1'b0}};
    writer_id_s    = {(NrVRegs*IdW){1'b0}};
    writer_valid_s = {NrVRegs{1'b0}};
    // Entries naming an instruction that is no longer running are invisible.
    for (int r = 0; r < int'(NrVRegs); r++) begin
      reader_live_s[r] = reader_r[r] & vinsn_cur_s;
      for (int i = 0; i < int'(NrVInsn); i++) begin
        writer_oh_s[r][i] = writer_valid_r[r] & (writer_id_r[r] == IdW'(i)) & vinsn_cur_s[i];
      end
    end
    haz_vs1_s = bus.req_use_vs1_i ? writer_oh_s[bus.req_vs1_i] : {NrVInsn{1'b0}};
    haz_vs2_s = bus.req_use_vs2_i ? writer_oh_s[bus.req_vs2_i] : {NrVInsn{1'b0}};
    haz_vm_s  = bus.req_vm_i ? {NrVInsn{1'b0}} : writer_oh_s[0];
    haz_vd_s  = bus.req_use_vd_i ? (writer_oh_s[bus.req_vd_i] | reader_live_s[bus.req_vd_i])
                                 : {NrVInsn{1'b0}};
    for (int r = 0; r < int'(NrVRegs); r++) begin
      writer_id_s[r]    = (alloc_s & bus.req_use_vd_i & (bus.req_vd_i == RegW'(r)))
                          ? free_id_s : writer_id_r[r];
      writer_valid_s[r] = (alloc_s & bus.req_use_vd_i & (bus.req_vd_i == RegW'(r)))
                          | (|writer_oh_s[r]);
      reader_s[r] = reader_live_s[r] |
                    ((alloc_s & ((bus.req_use_vs1_i & (bus.req_vs1_i == RegW'(r))) |
                                 (bus.req_use_vs2_i & (bus.req_vs2_i == RegW'(r))) |
                                 (~bus.req_vm_i & (r == 0))))
                     ? id_oh_s : {NrVInsn{1'b0}});
    end
  end

  // Issue FSM with registered broadcast outputs, plus scoreboard state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= ST_IDLE;
      running_r      <= {(NrPEs*NrVInsn){1'b0}};
      writer_id_r    <= {(NrVRegs*IdW){1'b0}};
      writer_valid_r <= {NrVRegs{1'b0}};
      reader_r       <= {(NrVRegs*NrVInsn){1'b0}};
      issue_valid_r  <= 1'b0;
      issue_id_r     <= {IdW{1'b0}};
      issue_mask_r   <= {NrPEs{1'b0}};
      acked_r        <= {NrPEs{1'b0}};
      haz_vs1_r      <= {NrVInsn{1'b0}};
      haz_vs2_r      <= {NrVInsn{1'b0}};
      haz_vm_r       <= {NrVInsn{1'b0}};
      haz_vd_r       <= {NrVInsn{1'b0}};
      idle_r         <= 1'b1;
    end else begin
      running_r      <= running_s;
      writer_id_r    <= writer_id_s;
      writer_valid_r <= writer_valid_s;
      reader_r       <= reader_s;
      idle_r         <= ~(|vinsn_next_s);
      case (state_r)
        ST_IDLE: begin
          if (alloc_s) begin
            state_r       <= ST_ISSUE;
            issue_valid_r <= 1'b1;
            issue_id_r    <= free_id_s;
            issue_mask_r  <= bus.req_pe_mask_i;
            acked_r       <= {NrPEs{1'b0}};
            haz_vs1_r     <= haz_vs1_s;
            haz_vs2_r     <= haz_vs2_s;
            haz_vm_r      <= haz_vm_s;
            haz_vd_r      <= haz_vd_s;
          end else begin
            issue_valid_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Dependencies that retire while the broadcast is held are released.
          haz_vs1_r <= haz_vs1_r & vinsn_next_s;
          haz_vs2_r <= haz_vs2_r & vinsn_next_s;
          haz_vm_r  <= haz_vm_r & vinsn_next_s;
          haz_vd_r  <= haz_vd_r & vinsn_next_s;
          if (ack_done_s) begin
            state_r       <= ST_IDLE;
            issue_valid_r <= 1'b0;
            acked_r       <= {NrPEs{1'b0}};
          end else begin
            acked_r <= acked_r | (bus.pe_ready_i & issue_mask_r);
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          issue_valid_r <= 1'b0;
          acked_r       <= {NrPEs{1'b0}};
        end
      endcase
    end
  end

  assign bus.req_ready_o     = req_ready_s;
  assign bus.issue_valid_o   = issue_valid_r;
  assign bus.issue_id_o      = issue_id_r;
  assign bus.issue_pe_mask_o = issue_mask_r;
  assign bus.hazard_vs1_o    = haz_vs1_r;
  assign bus.hazard_vs2_o    = haz_vs2_r;
  assign bus.hazard_vm_o     = haz_vm_r;
  assign bus.hazard_vd_o     = haz_vd_r;
  assign bus.vinsn_running_o = vinsn_next_s;
  assign bus.idle_o          = idle_r;
endmodule
